riscv_encode: RTL and testbench



---
 rtl/riscv_encode_if.sv | 29 ++
 rtl/riscv_encode.sv | 139 +++++++++++++
 tb/tb_riscv_encode.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_encode_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The master is the producer of field requests and the consumer of encoded words.
interface riscv_encode_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/riscv_encode.sv
// RV32I instruction encoder: packs separated fields into a 32-bit word,
// flags illegal opcodes and out-of-range/misaligned immediates, and buffers
// results in a 2-entry FIFO with valid/ready on both sides.
module riscv_encode #(
  parameter int          FIFO_DEPTH = 2,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst_n,
  riscv_encode_if.slave    bus,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0] imm;
  logic [6:0]  op;
  logic        imm12_ok;
  logic        imm13_ok;
  logic        imm21_ok;
  logic [31:0] raw_word;
  logic        enc_err;
  logic [31:0] enc_word;

  // Each entry is {err, word}.
  logic [32:0] mem [FIFO_DEPTH];
  logic [32:0] last_q;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        full;
  logic        push;
  logic        pop;

  assign imm      = bus.in_imm;
  assign op       = bus.in_opcode;
  assign imm12_ok = (imm[31:11] == {21{imm[11]}});
  assign imm13_ok = (imm[31:12] == {20{imm[12]}});
  assign imm21_ok = (imm[31:20] == {12{imm[20]}});

  // Format selection, bit packing and error detection for the current request.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    raw_word = NOP_WORD;
    enc_err  = 1'b0;
    case (op)
      OP_R: begin
        raw_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, op};
      end
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        raw_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, op};
        enc_err  = !imm12_ok;
      end
      OP_STORE: begin
        raw_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], op};
        enc_err  = !imm12_ok;
      end
      OP_BRANCH: begin
        raw_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    imm[4:1], imm[11], op};
        enc_err  = !imm13_ok || imm[0];
      end
      OP_LUI, OP_AUIPC: begin
        raw_word = {imm[31:12], bus.in_rd, op};
        enc_err  = (imm[11:0] != 12'd0);
      end
      OP_JAL: begin
        raw_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, op};
        enc_err  = !imm21_ok || imm[0];
      end
      default: begin
        enc_err = 1'b1;
      end
    endcase
  end

  assign enc_word = enc_err ? NOP_WORD : raw_word;

  // Readiness depends only on occupancy and reset, never on out_ready.
  assign full          = (count == 2'(FIFO_DEPTH));
  assign bus.in_ready  = rst_n && !full;
  assign bus.out_valid = (count != 2'd0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // When empty the outputs keep showing the most recently popped word.
  assign bus.out_instr = bus.out_valid ? mem[rd_ptr][31:0] : last_q[31:0];
  assign bus.out_err   = bus.out_valid ? mem[rd_ptr][32]   : last_q[32];

  // FIFO storage write; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are left unreset on purpose; only pointers and count need a known value.
    if (push) begin
      mem[wr_ptr] <= {enc_err, enc_word};
    end
  end

  // Pointers, occupancy, last-popped register and statistics counters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      last_q    <= '0;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        enc_count <= enc_count + CNT_W'(1);
        if (enc_err) begin
          err_count <= err_count + CNT_W'(1);
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_encode.sv
// Directed and randomised checks of the RV32I encoder and its output FIFO.
module tb_riscv_encode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  riscv_encode_if bus ();

  riscv_encode #(
    .FIFO_DEPTH (2),
    .CNT_W      (16),
    .NOP_WORD   (32'h0000_0013)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_vec   = 0;
  int n_bad   = 0;
  int exp_enc = 0;
  int exp_err = 0;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] word;
    logic        err;
  } vec_t;

  // Reference encoder built from shifts/masks and signed range checks.
  function automatic logic [32:0] ref_enc(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] imm);
    int          s;
    logic [31:0] w;
    logic        e;
    logic [31:0] f_rd, f_f3, f_rs1, f_rs2, f_op;
    s     = int'($signed(imm));
    w     = 32'd0;
    e     = 1'b0;
    f_rd  = 32'(rd) << 7;
    f_f3  = 32'(f3) << 12;
    f_rs1 = 32'(rs1) << 15;
    f_rs2 = 32'(rs2) << 20;
    f_op  = 32'(op);
    case (op)
      7'h33: w = (32'(f7) << 25) | f_rs2 | f_rs1 | f_f3 | f_rd | f_op;
      7'h13, 7'h03, 7'h67, 7'h73: begin
        e = (s < -2048) || (s > 2047);
        w = ((imm & 32'hFFF) << 20) | f_rs1 | f_f3 | f_rd | f_op;
      end
      7'h23: begin
        e = (s < -2048) || (s > 2047);
        w = (((imm >> 5) & 32'h7F) << 25) | f_rs2 | f_rs1 | f_f3 | ((imm & 32'h1F) << 7) | f_op;
      end
      7'h63: begin
        e = (s < -4096) || (s > 4095) || imm[0];
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | f_rs2 | f_rs1 | f_f3
          | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | f_op;
      end
      7'h37, 7'h17: begin
        e = ((imm & 32'hFFF) != 32'd0);
        w = (imm & 32'hFFFF_F000) | f_rd | f_op;
      end
      7'h6F: begin
        e = (s < -1048576) || (s > 1048575) || imm[0];
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
          | (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000F_F000) | f_rd | f_op;
      end
      default: e = 1'b1;
    endcase
    if (e) w = 32'h0000_0013;
    return {e, w};
  endfunction

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm);
    logic [32:0] r;
    int          waited;
    drive(op, rd, rs1, rs2, f3, f7, imm);
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_accept: in_ready=%b, expected 1 within 20 cycles", bus.in_ready);
    end else begin
      r = ref_enc(op, rd, rs1, rs2, f3, f7, imm);
      exp_enc++;
      exp_err += int'(r[32]);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_vec++; if (bus.out_instr !== 32'd0) begin n_bad++; $display("FAIL reset_out_instr: got %h expected 0", bus.out_instr); end
    n_vec++; if (bus.out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err: got %b expected 0", bus.out_err); end
    n_vec++; if (enc_count !== 16'd0 || err_count !== 16'd0) begin n_bad++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", enc_count, err_count); end
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_enc = 0;
    exp_err = 0;
    @(negedge clk);
    n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_r_type();
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL r_valid: got %b expected 1", bus.out_valid); end
    n_vec++; if (bus.out_instr !== 32'h002081B3) begin n_bad++; $display("FAIL r_instr: got %h expected 002081b3", bus.out_instr); end
    n_vec++; if (bus.out_err !== 1'b0) begin n_bad++; $display("FAIL r_err: got %b expected 0", bus.out_err); end
    n_vec++; if (enc_count !== 16'd1) begin n_bad++; $display("FAIL r_enc_count: got %0d expected 1", enc_count); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    @(negedge clk);
    n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready0: got %b expected 1", bus.in_ready); end
    @(posedge clk);
    #1;
    drive(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    @(negedge clk);
    n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready1: got %b expected 1", bus.in_ready); end
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00500093) begin n_bad++; $display("FAIL b2b_addi: got v=%b %h expected v=1 00500093", bus.out_valid, bus.out_instr); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    exp_enc += 2;
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h0020A423) begin n_bad++; $display("FAIL b2b_sw: got v=%b %h expected v=1 0020a423", bus.out_valid, bus.out_instr); end
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input vec_t v[]);
    foreach (v[i]) begin
      send(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].f3, v[i].f7, v[i].imm);
      @(negedge clk);
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== v[i].word || bus.out_err !== v[i].err) begin
        n_bad++;
        $display("FAIL %s: got v=%b %h err=%b expected v=1 %h err=%b", v[i].name,
                 bus.out_valid, bus.out_instr, bus.out_err, v[i].word, v[i].err);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_formats();
    vec_t v[];
    v = new[7];
    v[0] = '{"beq_p8",    7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,         32'h00208463, 1'b0};
    v[1] = '{"jal_p2048", 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'h001000EF, 1'b0};
    v[2] = '{"lui",       7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000,  32'h123452B7, 1'b0};
    v[3] = '{"addi_max",  7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000007FF,  32'h7FF00093, 1'b0};
    v[4] = '{"addi_min",  7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800,  32'h80000093, 1'b0};
    v[5] = '{"beq_p6",    7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd6,         32'h00208363, 1'b0};
    v[6] = '{"jal_m4",    7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC,  32'hFFDFF06F, 1'b0};
    run_table(v);
    v = new[1];
    v[0] = '{"auipc_neg", 7'h17, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF000,  32'hFFFFF117, 1'b0};
    run_table(v);
  endtask

  task automatic test_errors();
    vec_t v[];
    v = new[5];
    v[0] = '{"err_addi_2048", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h00000013, 1'b1};
    v[1] = '{"err_beq_odd",   7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd5,        32'h00000013, 1'b1};
    v[2] = '{"err_jal_odd",   7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        32'h00000013, 1'b1};
    v[3] = '{"err_lui_low",   7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h00000013, 1'b1};
    v[4] = '{"err_opcode",    7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0,        32'h00000013, 1'b1};
    run_table(v);
    n_vec++; if (err_count !== 16'd5) begin n_bad++; $display("FAIL err_count: got %0d expected 5", err_count); end
    n_vec++; if (enc_count !== 16'(exp_enc)) begin n_bad++; $display("FAIL enc_count_after_err: got %0d expected %0d", enc_count, exp_enc); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);             // A = 00500093
    @(negedge clk);
    n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_a: got %b expected 1", bus.in_ready); end
    @(posedge clk); #1;
    drive(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);             // B = 0020a423
    @(negedge clk);
    n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_b: got %b expected 1", bus.in_ready); end
    @(posedge clk); #1;
    drive(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);      // C = 123452b7
    @(negedge clk);
    n_vec++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready: got %b expected 0", bus.in_ready); end
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00500093) begin n_bad++; $display("FAIL bp_head_a: got v=%b %h expected v=1 00500093", bus.out_valid, bus.out_instr); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (bus.in_ready !== 1'b0 || bus.out_instr !== 32'h00500093) begin n_bad++; $display("FAIL bp_hold: got rdy=%b %h expected rdy=0 00500093", bus.in_ready, bus.out_instr); end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.in_ready !== 1'b0 || bus.out_instr !== 32'h00500093) begin n_bad++; $display("FAIL bp_release: got rdy=%b %h expected rdy=0 00500093", bus.in_ready, bus.out_instr); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (bus.in_ready !== 1'b1 || bus.out_instr !== 32'h0020A423) begin n_bad++; $display("FAIL bp_drain_b: got rdy=%b %h expected rdy=1 0020a423", bus.in_ready, bus.out_instr); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    exp_enc += 3;
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h123452B7) begin n_bad++; $display("FAIL bp_drain_c: got v=%b %h expected v=1 123452b7", bus.out_valid, bus.out_instr); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h123452B7) begin n_bad++; $display("FAIL bp_empty_last: got v=%b %h expected v=0 123452b7", bus.out_valid, bus.out_instr); end
    n_vec++; if (enc_count !== 16'(exp_enc)) begin n_bad++; $display("FAIL bp_enc_count: got %0d expected %0d", enc_count, exp_enc); end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b0;
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ready: got %b expected 0", bus.in_ready); end
    @(posedge clk); #1;
    rst_n   = 1'b1;
    exp_enc = 0;
    exp_err = 0;
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid: got %b expected 0", bus.out_valid); end
    n_vec++; if (enc_count !== 16'd0 || err_count !== 16'd0) begin n_bad++; $display("FAIL mid_reset_counts: got %0d/%0d expected 0/0", enc_count, err_count); end
    n_vec++; if (bus.out_instr !== 32'd0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset_out: got %h rdy=%b expected 0 rdy=1", bus.out_instr, bus.in_ready); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [6:0]  ops [12];
    logic [32:0] q [$];
    logic [32:0] r;
    logic [31:0] imm;
    int          drained;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h00};
    for (int cyc = 0; cyc < 400; cyc++) begin
      imm = $urandom;
      case ($urandom_range(0, 4))
        0: imm = imm;
        1: imm = {{20{imm[11]}}, imm[11:0]};
        2: imm = {{19{imm[12]}}, imm[12:1], 1'b0};
        3: imm = {imm[31:12], 12'd0};
        default: imm = {{11{imm[20]}}, imm[20:1], ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0};
      endcase
      drive(ops[$urandom_range(0, 11)], 5'($urandom), 5'($urandom), 5'($urandom),
            3'($urandom), 7'($urandom), imm);
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      n_vec++;
      if (bus.out_valid !== (q.size() != 0)) begin
        n_bad++;
        $display("FAIL rnd_valid: got %b expected %b at cycle %0d", bus.out_valid, (q.size() != 0), cyc);
      end
      if (bus.out_valid === 1'b1 && q.size() != 0) begin
        n_vec++;
        if ({bus.out_err, bus.out_instr} !== q[0]) begin
          n_bad++;
          $display("FAIL rnd_word: got err=%b %h expected err=%b %h at cycle %0d",
                   bus.out_err, bus.out_instr, q[0][32], q[0][31:0], cyc);
        end
        if (bus.out_ready) void'(q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        r = ref_enc(bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_funct3,
                    bus.in_funct7, bus.in_imm);
        q.push_back(r);
        exp_enc++;
        exp_err += int'(r[32]);
      end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drained = 0;
    while (q.size() != 0 && drained < 10) begin
      @(negedge clk);
      n_vec++;
      if (bus.out_valid !== 1'b1 || {bus.out_err, bus.out_instr} !== q[0]) begin
        n_bad++;
        $display("FAIL rnd_drain: got v=%b err=%b %h expected v=1 err=%b %h",
                 bus.out_valid, bus.out_err, bus.out_instr, q[0][32], q[0][31:0]);
      end
      void'(q.pop_front());
      @(posedge clk); #1;
      drained++;
    end
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b0 || q.size() != 0) begin n_bad++; $display("FAIL rnd_empty: got v=%b left=%0d expected v=0 left=0", bus.out_valid, q.size()); end
    n_vec++; if (enc_count !== 16'(exp_enc)) begin n_bad++; $display("FAIL rnd_enc_count: got %0d expected %0d", enc_count, exp_enc); end
    n_vec++; if (err_count !== 16'(exp_err)) begin n_bad++; $display("FAIL rnd_err_count: got %0d expected %0d", err_count, exp_err); end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_r_type();
    test_back_to_back();
    test_formats();
    test_errors();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
